// File: rtl/instr_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader_pkg
// Description : Shared definitions for the instruction-memory loader.
//               Holds the 3-bit instruction kind codes (identical to the
//               main decoder's type output), RV32I opcode constants, the
//               canonical NOP word and the loader FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_loader_pkg;

  // Instruction kind codes, identical to the decoder's type output
  localparam logic [2:0] KIND_LW  = 3'b000;
  localparam logic [2:0] KIND_SW  = 3'b001;
  localparam logic [2:0] KIND_R   = 3'b010;
  localparam logic [2:0] KIND_BEQ = 3'b011;
  localparam logic [2:0] KIND_JAL = 3'b100;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // addi x0, x0, 0 -- written in place of any unrecognised descriptor
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // funct3 used by lw/sw (word access) and beq
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage : instr_mem_loader_pkg
`default_nettype wire

// File: rtl/instr_mem_loader_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Purely combinational RV32I encoder. Turns an abstract
//               descriptor (kind + register fields + signed immediate) into
//               a 32-bit instruction word. Unknown kinds produce NOP_WORD and
//               raise the invalid flag. Also usable as a golden model.
// Ports       : kind     - 3-bit kind code (lw/sw/R/beq/jal)
//               rd       - destination register
//               rs1, rs2 - source registers
//               funct3   - R-type funct3 (ignored for other kinds)
//               funct7b5 - R-type instr[30]
//               imm      - 21-bit signed immediate; only the bits of each
//                          kind's field are used, the rest are ignored
//               word     - encoded instruction
//               invalid  - kind code not recognised
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
  import instr_mem_loader_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        invalid
);

  always_comb begin
    word    = NOP_WORD;
    invalid = 1'b0;
    case (kind)
      KIND_LW: begin
        word = {imm[11:0], rs1, F3_WORD, rd, OP_LW};
      end
      KIND_SW: begin
        word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_SW};
      end
      KIND_R: begin
        word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_R};
      end
      KIND_BEQ: begin
        // Branch offsets are half-word aligned; imm[0] is not encoded.
        word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BEQ};
      end
      KIND_JAL: begin
        // Jump offsets are half-word aligned; imm[0] is not encoded.
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      end
      default: begin
        word    = NOP_WORD;
        invalid = 1'b1;
      end
    endcase
  end

endmodule : instr_encoder
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader
// Description : Writer-side counterpart of the main decoder. Accepts
//               instruction descriptors over a valid/ready handshake,
//               encodes each into an RV32I word and writes the words to
//               consecutive instruction-memory addresses starting at BASE.
//               One word every two cycles (ACCEPT -> WRITE).
// Ports       : clk, rst_n          - clock / async active-low reset
//               start               - open a new session (IDLE/DONE only)
//               inValid/inReady     - descriptor handshake
//               inLast              - final descriptor of the session
//               kind, rd, rs1, rs2,
//               funct3, funct7b5,
//               imm                 - descriptor fields
//               memWe/memAddr/
//               memWdata            - instruction-memory write port
//               count               - words written this session
//               done                - session finished
//               full                - session ended on reaching DEPTH
//               err                 - invalid kind seen this session
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              inValid,
  output logic              inReady,
  input  logic              inLast,
  input  logic [2:0]        kind,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [20:0]       imm,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memWdata,
  output logic [ADDR_W-2:0] count,
  output logic              done,
  output logic              full,
  output logic              err
);

  // count can reach DEPTH, which needs ADDR_W-1 bits at most
  localparam logic [ADDR_W-2:0] C_DEPTH = (ADDR_W-1)'(DEPTH);
  localparam logic [ADDR_W-1:0] C_BASE  = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] C_STEP  = ADDR_W'(4);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [31:0]       r_word;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-2:0] r_count;
  logic              r_full;
  logic              r_err;

  logic [31:0]       w_word;
  logic              w_invalid;
  logic              w_accept;
  logic              w_restart;
  logic [ADDR_W-2:0] w_count_inc;
  logic              w_hit_depth;

  // --------------------------------------------------------------------------
  // Encoder
  // --------------------------------------------------------------------------
  instr_encoder u_encoder (
    .kind     (kind),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .imm      (imm),
    .word     (w_word),
    .invalid  (w_invalid)
  );

  // --------------------------------------------------------------------------
  // Control decodes
  // --------------------------------------------------------------------------
  assign w_accept    = (r_state == ST_ACCEPT) && inValid;
  assign w_restart   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
  assign w_count_inc = r_count + 1'b1;
  assign w_hit_depth = (w_count_inc == C_DEPTH);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (inValid) begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Capacity takes priority over inLast so full is always reported.
        if (w_hit_depth || r_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_ACCEPT;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_ACCEPT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_last  <= 1'b0;
      r_addr  <= C_BASE;
      r_count <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_restart) begin
        r_addr  <= C_BASE;
        r_count <= '0;
        r_full  <= 1'b0;
        r_err   <= 1'b0;
      end

      if (w_accept) begin
        r_word <= w_word;
        r_last <= inLast;
        if (w_invalid) begin
          r_err <= 1'b1;
        end
      end

      if (r_state == ST_WRITE) begin
        // Address wraps naturally modulo 2^ADDR_W.
        r_addr  <= r_addr + C_STEP;
        r_count <= w_count_inc;
        r_full  <= w_hit_depth;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // memWe decodes straight from the state register so an asynchronous
  // reset during WRITE drops it immediately.
  assign memWe    = (r_state == ST_WRITE);
  assign inReady  = (r_state == ST_ACCEPT);
  assign done     = (r_state == ST_DONE);
  assign memAddr  = r_addr;
  assign memWdata = r_word;
  assign count    = r_count;
  assign full     = r_full;
  assign err      = r_err;

endmodule : instr_mem_loader
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Directed self-checking bench for instr_mem_loader. Uses a
//               default-depth instance plus a DEPTH=4 instance for the
//               capacity scenario; shared descriptor inputs, separate start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        inValid = 1'b0;
  logic        inLast = 1'b0;
  logic [2:0]  kind = 3'd0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7b5 = 1'b0;
  logic [20:0] imm = 21'd0;

  logic        ready_a, we_a, done_a, full_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [6:0]  count_a;
  logic        ready_b, we_b, done_b, full_b, err_b;
  logic [7:0]  addr_b;
  logic [31:0] wdata_b;
  logic [6:0]  count_b;

  // sel picks which instance the shared tasks observe
  logic        sel = 1'b0;
  logic        m_ready, m_we, m_done, m_full, m_err;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [6:0]  m_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH(64), .ADDR_W(8), .BASE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .inValid(inValid),
    .inReady(ready_a), .inLast(inLast), .kind(kind), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(funct3), .funct7b5(funct7b5), .imm(imm),
    .memWe(we_a), .memAddr(addr_a), .memWdata(wdata_a), .count(count_a),
    .done(done_a), .full(full_a), .err(err_a)
  );

  instr_mem_loader #(.DEPTH(4), .ADDR_W(8), .BASE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .inValid(inValid),
    .inReady(ready_b), .inLast(inLast), .kind(kind), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(funct3), .funct7b5(funct7b5), .imm(imm),
    .memWe(we_b), .memAddr(addr_b), .memWdata(wdata_b), .count(count_b),
    .done(done_b), .full(full_b), .err(err_b)
  );

  assign m_ready = sel ? ready_b : ready_a;
  assign m_we    = sel ? we_b    : we_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_full  = sel ? full_b  : full_a;
  assign m_err   = sel ? err_b   : err_a;
  assign m_addr  = sel ? addr_b  : addr_a;
  assign m_wdata = sel ? wdata_b : wdata_a;
  assign m_count = sel ? count_b : count_a;

  // Pulse start on the selected instance for one clock edge.
  task automatic pulse_start();
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Offer one descriptor, check the write cycle, return one cycle later
  // (on a falling edge) with the post-write state visible.
  task automatic do_write(input logic [2:0] k, input logic [4:0] d,
                          input logic [4:0] s1, input logic [4:0] s2,
                          input logic [2:0] f3, input logic f7,
                          input logic [20:0] iv, input logic last,
                          input logic [7:0] exp_addr,
                          input logic [31:0] exp_data, input string nm);
    int waited;
    waited = 0;
    while (!m_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (!m_ready) begin
      bad++;
      $display("FAIL %s ready_timeout got=%b want=1", nm, m_ready);
      return;
    end
    kind = k; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7b5 = f7;
    imm = iv; inLast = last; inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    inLast  = 1'b0;
    total++;
    if (m_we !== 1'b1) begin
      bad++; $display("FAIL %s memWe got=%b want=1", nm, m_we);
    end
    total++;
    if (m_addr !== exp_addr) begin
      bad++; $display("FAIL %s memAddr got=%h want=%h", nm, m_addr, exp_addr);
    end
    total++;
    if (m_wdata !== exp_data) begin
      bad++; $display("FAIL %s memWdata got=%h want=%h", nm, m_wdata, exp_data);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (m_we !== 1'b0) begin
      bad++; $display("FAIL %s memWe_pulse got=%b want=0", nm, m_we);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({ready_a, we_a, done_a, full_a, err_a} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000",
                      {ready_a, we_a, done_a, full_a, err_a});
    end
    total++;
    if (addr_a !== 8'h00 || wdata_a !== 32'h0 || count_a !== 7'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%0d want=00/00000000/0",
                      addr_a, wdata_a, count_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (ready_a !== 1'b0) begin
      bad++; $display("FAIL idle_ready got=%b want=0", ready_a);
    end
  endtask

  task automatic test_lw();
    sel = 1'b0;
    pulse_start();
    total++;
    if (m_ready !== 1'b1) begin
      bad++; $display("FAIL lw_accept_ready got=%b want=1", m_ready);
    end
    do_write(3'b000, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 21'd8, 1'b0,
             8'h00, 32'h0081_2283, "lw");
    total++;
    if (m_count !== 7'd1 || m_ready !== 1'b1 || m_done !== 1'b0) begin
      bad++; $display("FAIL lw_after count=%0d ready=%b done=%b want 1/1/0",
                      m_count, m_ready, m_done);
    end
  endtask

  task automatic test_sw_rtype();
    do_write(3'b001, 5'd0, 5'd2, 5'd5, 3'd0, 1'b0, 21'd12, 1'b0,
             8'h04, 32'h0051_2623, "sw");
    do_write(3'b010, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0, 1'b0,
             8'h08, 32'h0020_81B3, "add");
    do_write(3'b010, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 21'd0, 1'b1,
             8'h0C, 32'h4020_81B3, "sub");
    total++;
    if (m_done !== 1'b1 || m_full !== 1'b0 || m_count !== 7'd4 || m_ready !== 1'b0) begin
      bad++; $display("FAIL last_done done=%b full=%b count=%0d ready=%b want 1/0/4/0",
                      m_done, m_full, m_count, m_ready);
    end
  endtask

  task automatic test_branch_jump();
    pulse_start();
    total++;
    if (m_done !== 1'b0 || m_count !== 7'd0 || m_ready !== 1'b1) begin
      bad++; $display("FAIL restart done=%b count=%0d ready=%b want 0/0/1",
                      m_done, m_count, m_ready);
    end
    do_write(3'b011, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'h1F_FFFC, 1'b0,
             8'h00, 32'hFE20_8EE3, "beq");
    do_write(3'b100, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd8, 1'b1,
             8'h04, 32'h0080_00EF, "jal");
    total++;
    if (m_done !== 1'b1 || m_count !== 7'd2 || m_err !== 1'b0) begin
      bad++; $display("FAIL bj_done done=%b count=%0d err=%b want 1/2/0",
                      m_done, m_count, m_err);
    end
  endtask

  task automatic test_invalid();
    pulse_start();
    do_write(3'b111, 5'd7, 5'd7, 5'd7, 3'd7, 1'b1, 21'h1F_FFFF, 1'b1,
             8'h00, 32'h0000_0013, "invalid");
    total++;
    if (m_err !== 1'b1 || m_done !== 1'b1 || m_count !== 7'd1) begin
      bad++; $display("FAIL inv_err err=%b done=%b count=%0d want 1/1/1",
                      m_err, m_done, m_count);
    end
    repeat (3) @(negedge clk);
    total++;
    if (m_err !== 1'b1) begin
      bad++; $display("FAIL inv_sticky got=%b want=1", m_err);
    end
    pulse_start();
    total++;
    if (m_err !== 1'b0) begin
      bad++; $display("FAIL inv_clear got=%b want=0", m_err);
    end
  endtask

  task automatic test_capacity();
    int wes;
    sel = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      do_write(3'b000, 5'(i + 1), 5'd0, 5'd0, 3'd0, 1'b0, 21'(4 * i), 1'b0,
               8'(4 * i), {12'(4 * i), 5'd0, 3'b010, 5'(i + 1), 7'b0000011},
               "cap");
    end
    total++;
    if (m_done !== 1'b1 || m_full !== 1'b1 || m_count !== 7'd4 || m_ready !== 1'b0) begin
      bad++; $display("FAIL cap_full done=%b full=%b count=%0d ready=%b want 1/1/4/0",
                      m_done, m_full, m_count, m_ready);
    end
    // Fifth descriptor must never be taken.
    wes = 0;
    inValid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_we || m_ready) wes++;
    end
    inValid = 1'b0;
    total++;
    if (wes !== 0 || m_count !== 7'd4) begin
      bad++; $display("FAIL cap_fifth activity=%0d count=%0d want 0/4", wes, m_count);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    int act;
    sel = 1'b0;
    pulse_start();
    kind = 3'b000; rd = 5'd1; rs1 = 5'd1; imm = 21'd4; inLast = 1'b0;
    inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (m_we !== 1'b1) begin
      bad++; $display("FAIL mid_we_before got=%b want=1", m_we);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (m_we !== 1'b0 || m_ready !== 1'b0 || m_count !== 7'd0) begin
      bad++; $display("FAIL mid_reset we=%b ready=%b count=%0d want 0/0/0",
                      m_we, m_ready, m_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_we || m_ready) act++;
    end
    inValid = 1'b0;
    total++;
    if (act !== 0 || m_count !== 7'd0 || m_done !== 1'b0) begin
      bad++; $display("FAIL mid_idle activity=%0d count=%0d done=%b want 0/0/0",
                      act, m_count, m_done);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_rtype();
    test_branch_jump();
    test_invalid();
    test_capacity();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instr_mem_loader
`default_nettype wire
